// File: rtl/rv_exec_pkg.sv
// Shared types and constants for the RV32I/M execute stage.
package rv_exec_pkg;

  // Bit 4 marks an M-extension op; for those the low three bits are funct3.
  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_SLL    = 5'b00010,
    OP_SLT    = 5'b00011,
    OP_SLTU   = 5'b00100,
    OP_XOR    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_OR     = 5'b01000,
    OP_AND    = 5'b01001,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } state_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ALU    = 2'b10;
  localparam logic [1:0] ALUOP_MEXT   = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic is_m_op(input op_e op);
    return op[4];
  endfunction

endpackage

// File: rtl/rv_exec_unit_if.sv
// Issue/result bundle between control decode, the execute stage and writeback.
interface rv_exec_unit_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       ALUOp;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             op5;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (
    output flush, in_valid, ALUOp, funct3, funct7_5, op5, SrcA, SrcB,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  flush, in_valid, ALUOp, funct3, funct7_5, op5, SrcA, SrcB,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/rv_muldiv_iter.sv
// Bit-serial multiply (shift-add) and restoring divide on magnitudes, with sign fixup.
module rv_muldiv_iter
  import rv_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  op_e                op_q;
  logic               a_neg_q, b_neg_q, b_zero_q;
  logic [WIDTH-1:0]   a_q, opnd_q;
  logic [2*WIDTH-1:0] acc_q, mul_next, div_next, prod;
  logic [WIDTH:0]     mul_sum, trial;
  logic [WIDTH-1:0]   quot, rem;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed && a[WIDTH-1];
  assign b_neg    = b_signed && b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  // Low half of acc starts as |a| for both: multiplier bits or dividend bits.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign done = busy_q && (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(WIDTH);
      op_q     <= op;
      a_neg_q  <= a_neg;
      b_neg_q  <= b_neg;
      b_zero_q <= (b == '0);
      a_q      <= a;
      opnd_q   <= b_mag;
      acc_q    <= {{WIDTH{1'b0}}, a_mag};
    end else if (busy_q) begin
      acc_q <= op_q[2] ? div_next : mul_next;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
  assign quot = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:                        result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               result = b_zero_q ? '1 : quot;
      OP_REM, OP_REMU:               result = b_zero_q ? a_q : rem;
      default:                       result = '0;
    endcase
  end
endmodule

// File: rtl/rv_exec_unit.sv
// Execute stage: op decode, single-cycle base ALU, iterative M-extension sequencing.
//   state   | meaning
//   IDLE    | accepting ops; base ops complete here in one cycle
//   MUL     | shift-add multiply iterating
//   DIV     | restoring divide iterating
//   FIN     | sign fixup done, result registered on leaving
module rv_exec_unit
  import rv_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  rv_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  op_e              op;
  state_e           state_q, state_d;
  logic             in_ready, accept, m_start, mdu_done;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res, mdu_res, res_d, res_q;
  logic             out_valid_d, out_valid_q, zero_q;

  assign shamt   = bus.SrcB[SHW-1:0];
  assign accept  = bus.in_valid && in_ready;
  assign m_start = accept && is_m_op(op);

  always_comb begin
    op = OP_ADD;
    case (bus.ALUOp)
      ALUOP_ADD:    op = OP_ADD;
      ALUOP_BRANCH: begin
        case (bus.funct3[2:1])
          2'b00:   op = OP_SUB;
          2'b10:   op = OP_SLT;
          2'b11:   op = OP_SLTU;
          default: op = OP_ADD;
        endcase
      end
      ALUOP_ALU: begin
        case (bus.funct3)
          F3_ADD:  op = (bus.op5 && bus.funct7_5) ? OP_SUB : OP_ADD;
          F3_SLL:  op = OP_SLL;
          F3_SLT:  op = OP_SLT;
          F3_SLTU: op = OP_SLTU;
          F3_XOR:  op = OP_XOR;
          F3_SR:   op = bus.funct7_5 ? OP_SRA : OP_SRL;
          F3_OR:   op = OP_OR;
          F3_AND:  op = OP_AND;
          default: op = OP_ADD;
        endcase
      end
      ALUOP_MEXT:   op = op_e'({2'b10, bus.funct3});
      default:      op = OP_ADD;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
      OP_SLL:  alu_res = bus.SrcA << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
      OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
      OP_SRL:  alu_res = bus.SrcA >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.SrcA) >>> shamt);
      OP_OR:   alu_res = bus.SrcA | bus.SrcB;
      OP_AND:  alu_res = bus.SrcA & bus.SrcB;
      default: alu_res = '0;
    endcase
  end

  rv_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (m_start),
    .abort  (bus.flush),
    .op     (op),
    .a      (bus.SrcA),
    .b      (bus.SrcB),
    .done   (mdu_done),
    .result (mdu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (m_start) state_d = op[2] ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: begin
        if (bus.flush)     state_d = ST_IDLE;
        else if (mdu_done) state_d = ST_FIN;
      end
      ST_FIN:         state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE) && !bus.flush;
  end

  // Result and Zero only move on a strobe, so writeback can sample them late.
  always_comb begin
    out_valid_d = 1'b0;
    res_d       = res_q;
    if (accept && !is_m_op(op)) begin
      out_valid_d = 1'b1;
      res_d       = alu_res;
    end else if ((state_q == ST_FIN) && !bus.flush) begin
      out_valid_d = 1'b1;
      res_d       = mdu_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= (res_d == '0);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_rv_exec_unit.sv
// Directed bench for rv_exec_unit with a result scoreboard keyed on expected arrival cycle.
module tb_rv_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_exec_unit_if #(.WIDTH(32)) bus ();
  rv_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out_valid got result %h exp no strobe", bus.ALUResult);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk32({e.tag, "_res"}, bus.ALUResult, e.res);
        chk32({e.tag, "_zero"}, {31'b0, bus.Zero}, {31'b0, e.res == 32'h0});
        chk_int({e.tag, "_cyc"}, cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                       input logic o5, input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp    = aop;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.op5      = o5;
    bus.SrcA     = a;
    bus.SrcB     = b;
    bus.in_valid = 1'b1;
  endtask

  // lat = clock edges between acceptance and result registration.
  task automatic issue(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                       input logic f7, input logic o5, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    drive(aop, f3, f7, o5, a, b);
    chk32({tag, "_rdy"}, {31'b0, bus.in_ready}, 32'd1);
    sb.push_back('{res: exp, cyc: cyc + 1 + lat, tag: tag});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue_silent(input logic [1:0] aop, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b);
    drive(aop, f3, 1'b0, 1'b1, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk_int({tag, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.funct3 = 3'b000;
    bus.funct7_5 = 1'b0; bus.op5 = 1'b0; bus.SrcA = '0; bus.SrcB = '0;

    #12;
    chk32("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk32("rst_result", bus.ALUResult, 32'd0);
    chk32("rst_zero", {31'b0, bus.Zero}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    #1 chk32("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);

    issue("sub",   2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
    issue("and",   2'b10, 3'b111, 1'b0, 1'b1, 32'd5, 32'd7, 32'd5, 0);
    issue("addi",  2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 0);
    issue("sra",   2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
    issue("srl",   2'b10, 3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000, 0);
    issue("sll",   2'b10, 3'b001, 1'b0, 1'b1, 32'd3, 32'd33, 32'd6, 0);
    issue("xor",   2'b10, 3'b100, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0);
    issue("add00", 2'b00, 3'b111, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    issue("blt",   2'b01, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    issue("bltu",  2'b01, 3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    issue("beq",   2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd4, 32'd5, 0);
    drain("base", 5);

    issue("mulh", 2'b11, 3'b001, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk_int("mulh_busy_cycles", n, 33);
    drain("mulh", 5);
    chk32("hold_result", bus.ALUResult, 32'h4000_0000);

    issue("div_ovf", 2'b11, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    drain("div_ovf", 40);
    issue("rem_ovf", 2'b11, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    drain("rem_ovf", 40);
    issue("divu_z", 2'b11, 3'b101, 1'b0, 1'b1, 32'd17, 32'd0, 32'hFFFF_FFFF, 33);
    drain("divu_z", 40);
    issue("rem_neg", 2'b11, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    drain("rem_neg", 40);
    issue("div_neg", 2'b11, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    drain("div_neg", 40);
    issue("rem_z", 2'b11, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 33);
    drain("rem_z", 40);
    issue("mul", 2'b11, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33);
    drain("mul", 40);
    issue("mulhsu", 2'b11, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    drain("mulhsu", 40);
    issue("mulhu", 2'b11, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    drain("mulhu", 40);
    issue("divu", 2'b11, 3'b101, 1'b0, 1'b1, 32'd100, 32'd3, 32'd33, 33);
    drain("divu", 40);
    issue("remu", 2'b11, 3'b111, 1'b0, 1'b1, 32'd100, 32'd3, 32'd1, 33);
    drain("remu", 40);

    // Flush a divide mid-flight; nothing may come out of it.
    issue_silent(2'b11, 3'b101, 32'd100, 32'd3);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    #1 chk32("flush_busy_rdy", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    #1 chk32("flush_idle_rdy_low", {31'b0, bus.in_ready}, 32'd0);
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd40, 32'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    #1 chk32("flush_release_rdy", {31'b0, bus.in_ready}, 32'd1);
    issue("add_after_flush", 2'b00, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 0);
    drain("add_after_flush", 5);
    repeat (40) @(negedge clk);

    // Async reset in the middle of a multiply.
    issue_silent(2'b11, 3'b000, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk32("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk32("mid_rst_result", bus.ALUResult, 32'd0);
    chk32("mid_rst_zero", {31'b0, bus.Zero}, 32'd1);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk32("post_rst_rdy", {31'b0, bus.in_ready}, 32'd1);
    repeat (40) @(negedge clk);
    issue("add_after_rst", 2'b10, 3'b110, 1'b0, 1'b1, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 0);
    drain("add_after_rst", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_exec_unit.md
Name: rv_exec_unit

Overview:
Parametrised execute-stage block for the RV32I/RV32M core.
- Decodes ALUOp, funct3, funct7 bits and op5 into an internal 4-bit operation code.
- Executes base-ISA ops in a single registered cycle.
- Executes M-extension multiply/divide ops iteratively at one bit per cycle.
- Sits between the main control decoder and the writeback mux. Uses a valid/ready input handshake, a one-cycle out_valid pulse and a synchronous flush for pipeline kills.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of any in-flight op
in_valid  in  1  operands and op fields valid
in_ready  out  1  block can accept this cycle
ALUOp  in  2  00 add, 01 branch compare, 10 R/I-type ALU, 11 M-extension
funct3  in  3  instruction funct3
funct7_5  in  1  instruction bit 30 (SUB/SRA select)
op5  in  1  opcode bit 5 (1 = R-type)
SrcA  in  WIDTH  operand A
SrcB  in  WIDTH  operand B / immediate
out_valid  out  1  one-cycle result strobe
ALUResult  out  WIDTH  result
Zero  out  1  ALUResult == 0, registered with the result

Behaviour:
- Reset, async, while rst_n = 0: state IDLE, out_valid = 0, ALUResult = 0, Zero = 1, in_ready = 1 once rst_n is released. Reset mid-iteration discards the op and produces no out_valid.
- in_ready = (state == IDLE) and not flush. An op is accepted on edge E0 when in_valid and in_ready are both high.
- Decode, combinational, into the internal code:
  - ALUOp 00: ADD.
  - ALUOp 01: funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; others -> ADD.
  - ALUOp 10: funct3 000 -> SUB if op5 and funct7_5, else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if funct7_5, else SRL; 110 OR; 111 AND.
  - ALUOp 11: funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Shifts use SrcB[SHW-1:0]. SLT/SLTU produce a zero-extended 0/1.
- Base ops: result, Zero and out_valid are registered at E0 and visible in cycle E0+1. State stays IDLE, so back-to-back issue is one op per cycle.
- FSM for M ops: IDLE -> MUL or DIV at E0. Operands are captured as absolute values where the op is signed, plus sign flags.
  - MUL/DIV: WIDTH iterations, one bit per cycle. MUL is shift-add into a 2*WIDTH accumulator; DIV is restoring.
  - Then FIN: sign fixup and result select. out_valid is set at edge E0+WIDTH+1. FIN -> IDLE.
  - Latency is fixed at WIDTH+1 for every M op, including special cases.
- Result selection: MUL = low WIDTH bits; MULH/MULHSU/MULHU = high WIDTH bits. MULHSU treats SrcA as signed and SrcB as unsigned. Product negation is done over the full 2*WIDTH bits.
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = SrcA.
- Signed overflow (SrcA = 100..0 and SrcB = all ones): DIV = SrcA; REM = 0.
- Remainder sign follows the dividend; quotient sign = XOR of the operand signs (zero result excluded).
- out_valid is high for exactly one cycle per accepted op. ALUResult and Zero hold their last value while out_valid is low.
- flush:
  - In MUL/DIV/FIN: return to IDLE next edge, no out_valid.
  - In IDLE with in_valid: nothing is accepted.
  - Same edge as a base-op result registration: out_valid is still suppressed.

Decomposition:
- Package rv_exec_pkg:
  - Internal 4-bit op enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Encoded with a 5th bit if needed; use the M-op flag plus funct3.
  - ALUOp constants.
  - FSM state enum: IDLE, MUL, DIV, FIN.
  - funct3 constants.
- One sub-module, rv_muldiv_iter:
  - Contains the iteration counter, accumulator/remainder registers and sign fixup.
  - Interface: start, abort, op, a, b -> done, result.
- The top module holds decode, the base ALU, the handshake and output registers.

Test Plan:
- Base ops: ALUOp=10, funct3=000, op5=1, funct7_5=1, SrcA=5, SrcB=7, issued on consecutive cycles with an AND op -> out_valid on two consecutive cycles; results 0xFFFFFFFE then 5&7=5; Zero=0 on both.
- Branch compare: ALUOp=01, funct3=100, SrcA=0xFFFFFFFF, SrcB=1 -> result 1 (SLT). Same operands with funct3=110 -> result 0 (SLTU).
- Multiply: ALUOp=11, funct3=001 (MULH), SrcA=0x80000000, SrcB=0x80000000 -> in_ready low for 33 cycles; out_valid exactly 33 cycles after accept; result 0x40000000.
- Divide special cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
  - DIVU 17/0 -> 0xFFFFFFFF.
  - REM -7/2 -> 0xFFFFFFFF (-1).
  - Each with out_valid after 33 cycles.
- Flush: start DIVU 100/3, assert flush at cycle 10 -> no out_valid, in_ready high the next cycle. A following ADD 2+3 -> 5 after 1 cycle.
- Reset: drop rst_n mid-MUL asynchronously -> out_valid=0, ALUResult=0, Zero=1 immediately. After release, in_ready=1 and no stale out_valid appears.
